// File: rtl/rtc_mux_bus_engine_if.sv
// rtl/rtc_mux_bus_engine_if.sv - host handshake and RTC pin bundle for rtc_mux_bus_engine
//
// Purpose: groups the host transaction handshake and the multiplexed RTC bus
// pins into one bundle. The engine connects through the slave modport; the
// host (or bench) side uses the master modport.
//
// Signals:
//   req, we, addr, burst_len, wdata  host -> engine transaction request
//   wnext, busy, done                engine -> host handshake pulses/levels
//   rd_valid, rd_data                engine -> host read return
//   ADin                             RTC pins -> engine (bus input)
//   ADout, drv_en, ad, cs, wr, rd    engine -> RTC pins (strobes active low)
interface rtc_mux_bus_engine_if #(
  parameter int DW   = 8,
  parameter int BL_W = 4
) ();
  logic            req;
  logic            we;
  logic [DW-1:0]   addr;
  logic [BL_W-1:0] burst_len;
  logic [DW-1:0]   wdata;
  logic            wnext;
  logic            busy;
  logic            done;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic [DW-1:0]   ADin;
  logic [DW-1:0]   ADout;
  logic            drv_en;
  logic            ad;
  logic            cs;
  logic            wr;
  logic            rd;

  modport slave (
    input  req, we, addr, burst_len, wdata, ADin,
    output wnext, busy, done, rd_valid, rd_data, ADout, drv_en, ad, cs, wr, rd
  );

  modport master (
    output req, we, addr, burst_len, wdata, ADin,
    input  wnext, busy, done, rd_valid, rd_data, ADout, drv_en, ad, cs, wr, rd
  );
endinterface

// File: rtl/rtc_mux_bus_engine.sv
// rtl/rtc_mux_bus_engine.sv - transaction engine for the multiplexed address/data RTC bus
//
// Purpose: runs single or burst reads/writes on the RTC ad/cs/wr/rd bus with
// parametrised strobe, turnaround and recovery timing, stepping the register
// address once per beat.
//
// Ports:
//   clock  system clock
//   reset  synchronous, active-high reset (aborts any beat in progress)
//   bus    rtc_mux_bus_engine_if.slave: host handshake + RTC pins
//
// Every beat is sequenced by r_off, the index of the current edge within the
// beat (1 = E1, the edge that drops ad). Each strobe change is decoded from
// the offset of the edge being taken (w_n); r_state only selects which group
// of offsets is live so read and write timelines cannot interfere.
module rtc_mux_bus_engine #(
  parameter int DW       = 8,
  parameter int BL_W     = 4,
  parameter int T_STB    = 6,
  parameter int T_TURN   = 8,
  parameter int T_REC    = 10,
  parameter int ADDR_DEC = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  rtc_mux_bus_engine_if.slave  bus
);

  // Last strobe-changing edge of each beat type; recovery counts from here.
  localparam int N_RD_LAST = 7 + 2 * T_STB + T_TURN;
  localparam int N_WR_LAST = 9 + 2 * T_STB;
  localparam int N_MAX     = ((N_RD_LAST > N_WR_LAST) ? N_RD_LAST : N_WR_LAST) + T_REC + 1;
  localparam int CW        = $clog2(N_MAX + 1);

  typedef logic [CW-1:0] off_t;

  // Address phase, shared by reads and writes.
  localparam off_t O_AD_LO    = off_t'(1);
  localparam off_t O_CS_LO    = off_t'(2);
  localparam off_t O_WR_LO    = off_t'(3);
  localparam off_t O_WR_HI    = off_t'(3 + T_STB);
  localparam off_t O_CS_HI    = off_t'(4 + T_STB);
  localparam off_t O_AD_HI    = off_t'(5 + T_STB);
  // Read data phase: bus released at O_AD_HI, then turnaround before cs.
  localparam off_t O_R_CS_LO  = off_t'(5 + T_STB + T_TURN);
  localparam off_t O_R_RD_LO  = off_t'(6 + T_STB + T_TURN);
  localparam off_t O_R_RD_HI  = off_t'(6 + 2 * T_STB + T_TURN);
  localparam off_t O_R_CS_HI  = off_t'(N_RD_LAST);
  // Write data phase: engine keeps driving, data replaces the address.
  localparam off_t O_W_CS_LO  = off_t'(6 + T_STB);
  localparam off_t O_W_WR_LO  = off_t'(7 + T_STB);
  localparam off_t O_W_WR_HI  = off_t'(7 + 2 * T_STB);
  localparam off_t O_W_CS_HI  = off_t'(8 + 2 * T_STB);
  localparam off_t O_W_REL    = off_t'(N_WR_LAST);
  // Edge that either opens the next beat or completes the transaction.
  localparam off_t O_R_END    = off_t'(N_RD_LAST + T_REC + 1);
  localparam off_t O_W_END    = off_t'(N_WR_LAST + T_REC + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_RDAT = 3'd2;
  localparam logic [2:0] S_WDAT = 3'd3;
  localparam logic [2:0] S_REC  = 3'd4;

  logic [2:0]      r_state;
  off_t            r_off;
  logic [BL_W-1:0] r_beats_left;
  logic            r_we;
  logic [DW-1:0]   r_addr;

  logic            r_ad;
  logic            r_cs;
  logic            r_wr;
  logic            r_rd;
  logic [DW-1:0]   r_adout;
  logic            r_drv_en;
  logic            r_busy;
  logic            r_done;
  logic            r_rd_valid;
  logic            r_wnext;
  logic [DW-1:0]   r_rd_data;

  off_t            w_n;
  off_t            w_end;
  logic [DW-1:0]   w_addr_step;

  assign w_n   = r_off + off_t'(1);
  assign w_end = r_we ? O_W_END : O_R_END;
  // Natural modulo-2^DW wrap gives 0x00 -> 0xFF and 0xFF -> 0x00.
  assign w_addr_step = (ADDR_DEC != 0) ? (r_addr - DW'(1)) : (r_addr + DW'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_off        <= '0;
      r_beats_left <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_ad         <= 1'b1;
      r_cs         <= 1'b1;
      r_wr         <= 1'b1;
      r_rd         <= 1'b1;
      r_adout      <= '1;
      r_drv_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_wnext      <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      // Single-cycle pulses fall unless re-asserted below.
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wnext    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_we         <= bus.we;
            r_addr       <= bus.addr;
            r_beats_left <= (bus.burst_len == '0) ? BL_W'(1) : bus.burst_len;
            r_busy       <= 1'b1;
            r_off        <= '0;
            r_state      <= S_ADDR;
          end
        end

        S_ADDR: begin
          r_off <= w_n;
          if (w_n == O_AD_LO) r_ad <= 1'b0;
          if (w_n == O_CS_LO) r_cs <= 1'b0;
          if (w_n == O_WR_LO) begin
            r_wr     <= 1'b0;
            r_adout  <= r_addr;
            r_drv_en <= 1'b1;
          end
          if (w_n == O_WR_HI) r_wr <= 1'b1;
          if (w_n == O_CS_HI) r_cs <= 1'b1;
          if (w_n == O_AD_HI) begin
            r_ad <= 1'b1;
            if (r_we) begin
              // wdata is taken here; wnext tells the host to present the next byte.
              r_adout <= bus.wdata;
              r_wnext <= 1'b1;
              r_state <= S_WDAT;
            end else begin
              // Release the bus so the RTC can drive it after the turnaround.
              r_adout  <= '1;
              r_drv_en <= 1'b0;
              r_state  <= S_RDAT;
            end
          end
        end

        S_RDAT: begin
          r_off <= w_n;
          if (w_n == O_R_CS_LO) r_cs <= 1'b0;
          if (w_n == O_R_RD_LO) r_rd <= 1'b0;
          if (w_n == O_R_RD_HI) begin
            r_rd       <= 1'b1;
            r_rd_data  <= bus.ADin;
            r_rd_valid <= 1'b1;
          end
          if (w_n == O_R_CS_HI) begin
            r_cs    <= 1'b1;
            r_state <= S_REC;
          end
        end

        S_WDAT: begin
          r_off <= w_n;
          if (w_n == O_W_CS_LO) r_cs <= 1'b0;
          if (w_n == O_W_WR_LO) r_wr <= 1'b0;
          if (w_n == O_W_WR_HI) r_wr <= 1'b1;
          if (w_n == O_W_CS_HI) r_cs <= 1'b1;
          if (w_n == O_W_REL) begin
            r_drv_en <= 1'b0;
            r_adout  <= '1;
            r_state  <= S_REC;
          end
        end

        S_REC: begin
          r_off <= w_n;
          if (w_n == w_end) begin
            if (r_beats_left <= BL_W'(1)) begin
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_beats_left <= '0;
              r_off        <= '0;
              r_state      <= S_IDLE;
            end else begin
              // This edge is E1 of the following beat.
              r_beats_left <= r_beats_left - BL_W'(1);
              r_addr       <= w_addr_step;
              r_off        <= O_AD_LO;
              r_ad         <= 1'b0;
              r_state      <= S_ADDR;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_off   <= '0;
        end
      endcase
    end
  end

  assign bus.ad       = r_ad;
  assign bus.cs       = r_cs;
  assign bus.wr       = r_wr;
  assign bus.rd       = r_rd;
  assign bus.ADout    = r_adout;
  assign bus.drv_en   = r_drv_en;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rd_valid = r_rd_valid;
  assign bus.wnext    = r_wnext;
  assign bus.rd_data  = r_rd_data;

endmodule
